// File: rtl/error_stream_gen.sv
// Multi-round surface-code error stream generator.
// Per-lane Galois LFSRs feed persistent data errors and transient measurement errors.
module error_stream_gen #(
  parameter int          CODE_DISTANCE_X = 5,
  parameter int          CODE_DISTANCE_Z = 4,
  parameter int          NUM_ROUNDS      = CODE_DISTANCE_X,
  parameter int          LANES           = 4,
  parameter logic [31:0] SEED            = 32'hACE12468,
  localparam int MEAS_WIDTH = (CODE_DISTANCE_X - 1) * CODE_DISTANCE_Z,
  localparam int NUM_CHUNKS = (MEAS_WIDTH + LANES - 1) / LANES,
  localparam int ROUND_W    = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  next,
  input  logic [15:0]           p_data,
  input  logic [15:0]           p_meas,
  input  logic                  ready,
  output logic                  busy,
  output logic                  valid,
  output logic [MEAS_WIDTH-1:0] measurement_values,
  output logic [ROUND_W-1:0]    round_index,
  output logic                  last_round
);

  localparam int          CHUNK_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [31:0] TAPS    = 32'h80200003;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    HOLD
  } state_t;

  state_t                state_q;
  logic                  busy_q;
  logic                  valid_q;
  logic [MEAS_WIDTH-1:0] meas_q;
  logic [MEAS_WIDTH-1:0] syn_q;
  logic [15:0]           pd_q;
  logic [15:0]           pm_q;
  logic [CHUNK_W-1:0]    chunk_q;
  logic [ROUND_W-1:0]    round_q;
  logic                  last_q;

  logic [ROUND_W-1:0]    round_d;
  logic [LANES-1:0]      ed;
  logic [LANES-1:0]      em;
  logic [MEAS_WIDTH-1:0] hit;
  logic [MEAS_WIDTH-1:0] syn_d;
  logic [MEAS_WIDTH-1:0] meas_d;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam logic [31:0] S0 = SEED ^ (32'(l) * 32'h9E3779B9);
    localparam logic [31:0] SI = (S0 == 32'h0) ? 32'h1 : S0;
    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;
    logic [15:0] rand_d;
    logic [15:0] rand_m;

    assign rand_d = lfsr_q[15:0];
    assign rand_m = lfsr_q[31:16];
    assign lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);
    assign ed[l]  = (rand_d < pd_q) | (&pd_q);
    assign em[l]  = (rand_m < pm_q) | (&pm_q);

    always_ff @(posedge clk) begin
      if (!reset) begin
        lfsr_q <= SI;
      end else if (state_q == GEN) begin
        lfsr_q <= lfsr_d;
      end
    end
  end

  // Bit b belongs to lane b%LANES and is written in chunk b/LANES.
  for (genvar b = 0; b < MEAS_WIDTH; b++) begin : g_bit
    localparam int L = b % LANES;
    localparam int C = b / LANES;
    assign hit[b]    = (chunk_q == CHUNK_W'(C));
    assign syn_d[b]  = syn_q[b] ^ ed[L];
    assign meas_d[b] = syn_d[b] ^ (em[L] & ~last_q);
  end

  assign round_d = last_q ? '0 : round_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      meas_q  <= '0;
      syn_q   <= '0;
      pd_q    <= '0;
      pm_q    <= '0;
      chunk_q <= '0;
      round_q <= '0;
      last_q  <= (NUM_ROUNDS == 1);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (next) begin
            pd_q    <= p_data;
            pm_q    <= p_meas;
            chunk_q <= '0;
            busy_q  <= 1'b1;
            state_q <= GEN;
            if (round_q == '0) syn_q <= '0;
          end
        end
        GEN: begin
          syn_q   <= (syn_q & ~hit) | (syn_d & hit);
          meas_q  <= (meas_q & ~hit) | (meas_d & hit);
          chunk_q <= chunk_q + 1'b1;
          if (chunk_q == CHUNK_W'(NUM_CHUNKS - 1)) begin
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            round_q <= round_d;
            last_q  <= (round_d == ROUND_W'(NUM_ROUNDS - 1));
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy               = busy_q;
  assign valid              = valid_q;
  assign measurement_values = meas_q;
  assign round_index        = round_q;
  assign last_round         = last_q;

endmodule

// File: tb/tb_error_stream_gen.sv
// Directed bench for error_stream_gen with a scoreboard fed
// by an independent LFSR/syndrome reference model.
module tb_error_stream_gen;

  localparam int          MW   = 16;
  localparam int          NR   = 5;
  localparam int          NC   = 4;
  localparam int          LN   = 4;
  localparam logic [31:0] SEED = 32'hACE12468;
  localparam logic [31:0] TAPS = 32'h80200003;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        next   = 1'b0;
  logic        ready  = 1'b0;
  logic [15:0] p_data = '0;
  logic [15:0] p_meas = '0;
  logic        busy;
  logic        valid;
  logic [15:0] mv;
  logic [2:0]  ridx;
  logic        last;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] mv;
    logic [2:0]  idx;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_lfsr[LN];
  logic [15:0] m_syn;
  int          m_round;
  logic [15:0] seq1[64];
  logic [15:0] seq2[64];

  error_stream_gen dut (
    .clk               (clk),
    .reset             (reset),
    .next              (next),
    .p_data            (p_data),
    .p_meas            (p_meas),
    .ready             (ready),
    .busy              (busy),
    .valid             (valid),
    .measurement_values(mv),
    .round_index       (ridx),
    .last_round        (last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int l = 0; l < LN; l++) begin
      logic [31:0] s;
      s = SEED ^ (l * 32'h9E3779B9);
      m_lfsr[l] = (s == 0) ? 32'h1 : s;
    end
    m_syn   = '0;
    m_round = 0;
  endfunction

  function automatic logic m_err(input logic [15:0] p, input logic [15:0] r);
    if (p == 16'hFFFF) return 1'b1;
    return (r < p);
  endfunction

  function automatic void m_push(input logic [15:0] pd, input logic [15:0] pm);
    exp_t        e;
    logic [15:0] out;
    logic        lr;
    if (m_round == 0) m_syn = '0;
    lr  = (m_round == NR - 1);
    out = '0;
    for (int c = 0; c < NC; c++) begin
      for (int l = 0; l < LN; l++) begin
        int   b;
        logic s;
        b = c * LN + l;
        if (b < MW) begin
          s        = m_syn[b] ^ m_err(pd, m_lfsr[l][15:0]);
          m_syn[b] = s;
          out[b]   = s ^ (m_err(pm, m_lfsr[l][31:16]) & ~lr);
        end
        m_lfsr[l] = m_lfsr[l][0] ? ((m_lfsr[l] >> 1) ^ TAPS) : (m_lfsr[l] >> 1);
      end
    end
    e.mv   = out;
    e.idx  = 3'(m_round);
    e.last = lr;
    sb.push_back(e);
    m_round = lr ? 0 : m_round + 1;
  endfunction

  task automatic issue(input logic [15:0] pd, input logic [15:0] pm);
    next   = 1'b1;
    p_data = pd;
    p_meas = pm;
    m_push(pd, pm);
    @(negedge clk);
    next = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("valid_seen", valid, 1);
  endtask

  task automatic take(output logic [15:0] got);
    exp_t e;
    chk("sb_depth", sb.size(), 1);
    got = mv;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("meas", mv, e.mv);
      chk("round_index", ridx, e.idx);
      chk("last_round", last, e.last);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      chk("valid_drop", valid, 0);
      chk("ridx_next", ridx, e.last ? 3'd0 : e.idx + 3'd1);
    end
  endtask

  task automatic round(input logic [15:0] pd, input logic [15:0] pm, output logic [15:0] got);
    int lat;
    issue(pd, pm);
    wait_valid(lat);
    chk("latency", lat, NC);
    take(got);
  endtask

  initial begin
    logic [15:0] got;
    logic [15:0] held;
    int          lat;
    int          ones;
    int          bits;

    // Reset with next asserted
    m_reset();
    reset = 1'b0;
    next  = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_meas", mv, 0);
      chk("rst_ridx", ridx, 0);
      chk("rst_last", last, 0);
    end
    next  = 1'b0;
    reset = 1'b1;

    // Zero noise
    for (int r = 0; r < NR; r++) begin
      round(16'h0, 16'h0, got);
      chk("zero_round", got, 16'h0000);
    end

    // Measurement-only noise
    for (int r = 0; r < NR; r++) begin
      round(16'h0, 16'hFFFF, got);
      chk("meas_only", got, (r < NR - 1) ? 16'hFFFF : 16'h0000);
    end

    // Data-only noise, plus first round of the following batch
    for (int r = 0; r < NR + 1; r++) begin
      round(16'hFFFF, 16'h0, got);
      chk("data_only", got, (r % NR == 1 || r % NR == 3) ? 16'h0000 : 16'hFFFF);
    end

    // Backpressure; next held high through GEN and pulsed in HOLD
    issue(16'h0000, 16'h4000);
    next = 1'b1;
    wait_valid(lat);
    chk("bp_latency", lat, NC);
    held = mv;
    for (int i = 0; i < 20; i++) begin
      next = i[0];
      @(negedge clk);
      chk("bp_stable", mv, held);
      chk("bp_valid", valid, 1);
      chk("bp_busy", busy, 1);
    end
    next = 1'b0;
    take(got);
    repeat (3) begin
      @(negedge clk);
      chk("bp_no_extra", valid, 0);
      chk("bp_idle", busy, 0);
    end

    // Determinism from reset and statistics
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_reset();
    sb.delete();
    ones = 0;
    bits = 0;
    for (int r = 0; r < 64; r++) begin
      round(16'h0, 16'h1000, got);
      seq1[r] = got;
      if (r % NR != NR - 1) begin
        ones += $countones(got);
        bits += MW;
      end
    end
    chk("density_lo", (ones * 100 >= bits * 4), 1);
    chk("density_hi", (ones * 100 <= bits * 9), 1);

    issue(16'h0, 16'h1000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midgen_valid", valid, 0);
    chk("midgen_busy", busy, 0);
    chk("midgen_meas", mv, 0);
    reset = 1'b1;
    m_reset();
    sb.delete();
    for (int r = 0; r < 64; r++) begin
      round(16'h0, 16'h1000, got);
      seq2[r] = got;
    end
    for (int r = 0; r < 64; r++) begin
      chk("replay", seq2[r], seq1[r]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/error_stream_gen.md
# error_stream_gen

Parametrised, multi-round error stream generator for the surface-code decoder test environment. On each `next` request it produces one round of `measurement_values` for a CODE_DISTANCE_X × CODE_DISTANCE_Z lattice, with two independent, runtime-programmable error probabilities:

- data errors, which persist and accumulate across rounds;
- measurement errors, which are transient.

A batch is NUM_ROUNDS rounds, and the final round is always error-free in measurement. Output is held under a valid/ready handshake so decoder-side benches can apply backpressure.

## Interface

**Parameters**
- CODE_DISTANCE_X, default 5: lattice distance, X direction.
- CODE_DISTANCE_Z, default 4: lattice distance, Z direction.
- NUM_ROUNDS, default CODE_DISTANCE_X: rounds per batch, ≥1.
- LANES, default 4: bits generated per cycle, ≥1.
- SEED, default 32'hACE12468: base LFSR seed.
- Derived: MEAS_WIDTH = (CODE_DISTANCE_X-1)*CODE_DISTANCE_Z; NUM_CHUNKS = ceil(MEAS_WIDTH/LANES); ROUND_W = max(1, $clog2(NUM_ROUNDS)).

**Ports**
- clk, in, 1: single clock, all logic on posedge.
- reset, in, 1: synchronous, active-low.
- next, in, 1: request one round; honoured only in IDLE.
- p_data, in, 16: data-error probability threshold, sampled on accepted `next`.
- p_meas, in, 16: measurement-error probability threshold, sampled on accepted `next`.
- ready, in, 1: consumer accepts the held round.
- busy, out, 1: high in GEN or HOLD.
- valid, out, 1: round available; high only in HOLD.
- measurement_values, out, MEAS_WIDTH: round result.
- round_index, out, ROUND_W: index of the current/held round within the batch.
- last_round, out, 1: round_index == NUM_ROUNDS-1.

## Operation

**LFSRs**
- One 32-bit Galois LFSR per lane, taps 32'h80200003.
- Lane l is seeded with SEED ^ (l*32'h9E3779B9); a zero result is replaced by 32'h1.
- All LFSRs advance once per GEN cycle only.
- rand_d = lfsr[15:0], rand_m = lfsr[31:16].

**Error decision**
- err(p, r) = (r < p) | (p == 16'hFFFF).
- p = 0 never produces an error; p = 16'hFFFF always does.

**State**
- `syn`, MEAS_WIDTH bits: accumulated data-error parity.
- `pd`, `pm`: latched thresholds.
- `chunk` counter.
- `round_index`.

**FSM (IDLE → GEN → HOLD → IDLE)**
- IDLE, `next` = 1:
  - latch p_data/p_meas into pd/pm; chunk ← 0; go to GEN.
  - If round_index == 0, clear syn.
- GEN, each cycle: for each lane l, bit b = chunk*LANES + l. If b < MEAS_WIDTH:
  - s = syn[b] ^ err(pd, rand_d);
  - syn[b] ← s;
  - measurement_values[b] ← s ^ (err(pm, rand_m) & ~last_round).
  - Lanes with b ≥ MEAS_WIDTH still advance their LFSR but write nothing.
  - chunk increments; after the cycle with chunk == NUM_CHUNKS-1, go to HOLD.
- HOLD: valid = 1; measurement_values stable.
  - On valid & ready: round_index ← (last_round ? 0 : round_index+1); go to IDLE.
- `next` in GEN or HOLD is ignored, not queued.

**Reset**
- Outputs: valid = 0, busy = 0, measurement_values = 0, round_index = 0, last_round = (NUM_ROUNDS == 1).
- FSM → IDLE, syn = 0, LFSRs reseeded.
- Reset mid-GEN or mid-HOLD discards the round. The following sequence is identical to one issued from power-on.

## Timing

- `next` sampled high at edge k: GEN covers edges k+1 … k+NUM_CHUNKS; valid is high after edge k+NUM_CHUNKS.
- Defaults (MEAS_WIDTH 16, LANES 4): valid rises 4 cycles after the `next` edge.
- Handshake completes on the edge where valid & ready. valid drops after that edge. round_index/last_round update on the same edge.
- Earliest new `next` is accepted one edge after the handshake edge, so minimum round period = NUM_CHUNKS + 2 cycles.
- ready high while valid is low has no effect.
- measurement_values changes only during GEN; it is stale while valid is low.
- round_index wraps NUM_ROUNDS-1 → 0. The next accepted `next` starts a new batch with syn cleared.

## Test plan

1. **Reset.** Drive reset = 0 for 2 cycles with `next` = 1.
   - Required: valid = 0, busy = 0, measurement_values = 0, round_index = 0 throughout.
   - After release, the first `next` is accepted normally.
2. **Zero noise.** p_data = 0, p_meas = 0; run 5 rounds with ready = 1.
   - Required: every round = 16'h0000; round_index 0,1,2,3,4; last_round only on round 4; round_index returns to 0.
3. **Measurement-only noise.** p_data = 0, p_meas = 16'hFFFF.
   - Required: rounds 0–3 = 16'hFFFF; round 4 = 16'h0000.
4. **Data-only noise.** p_data = 16'hFFFF, p_meas = 0.
   - Required: rounds 0–4 = FFFF, 0000, FFFF, 0000, FFFF.
   - The next batch's round 0 = FFFF (syn cleared).
5. **Backpressure and latency.** `next` at edge 0.
   - Required: valid rises after edge 4.
   - Hold ready = 0 for 20 cycles while pulsing `next`. Required: output stable, busy = 1, no extra round.
   - Then ready = 1. Required: single handshake, round_index +1.
6. **Determinism and statistics.** p_data = 0, p_meas = 16'h1000.
   - Run 64 rounds, assert reset mid-GEN, rerun. Required: identical 64-round sequences.
   - Required: set-bit density between 4% and 9%.
